bus_responder: RTL and testbench
================================

Name: bus_responder

Overview:
- Memory-side responder for the CPU's byte-wide bus (addr, rdata, wdata, read_en, write_en).
- Decodes the 16-bit address into internal regions: ROM, WRAM with its echo, HRAM, and the IF/IE interrupt registers. Returns read data with a fixed one-clock latency and commits writes exactly once per bus write cycle.
- Sits between the CPU and the memory arrays. It is the first consumer of the CPU's T1–T4 bus timing.

Parameters:
- ROM_AW, 15, ROM address width (32 KiB at 0x0000–0x7FFF).
- WRAM_AW, 13, WRAM address width (8 KiB at 0xC000–0xDFFF).
- UNMAPPED_VAL, 8'hFF, read value for unmapped or unimplemented addresses.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- bus  modport  Bus_if.Memory_side  CPU bus: addr[15:0] in, wdata[7:0] in, read_en in, write_en in, rdata[7:0] out
- rom_we  in  1  ROM preload strobe (bench/boot loader)
- rom_waddr  in  ROM_AW  ROM preload address
- rom_wdata  in  8  ROM preload data
- irq_req  in  5  per-source interrupt set pulses (VBlank, STAT, Timer, Serial, Joypad)
- if_q  out  5  current IF[4:0]
- ie_q  out  8  current IE

Behaviour:
- Reset values:
  - rdata = UNMAPPED_VAL
  - IF[4:0] = 0
  - IE = 0
  - write-edge tracker = 0
  - ROM/WRAM/HRAM contents are not reset.
- Reads:
  - rdata is registered every clk from the current addr, independent of read_en.
  - Latency: data for the addr present before edge N appears after edge N.
  - The CPU drives addr at T1 and samples at the T3 edge, so data is stable in time.
- Address map, first match wins:
  - 0x0000–0x7FFF: ROM, read-only. Writes are ignored; MBC is out of scope.
  - 0xC000–0xDFFF: WRAM.
  - 0xE000–0xFDFF: echo of WRAM, index addr[12:0]. Reads and writes both apply.
  - 0xFF0F: IF. Reads {3'b111, IF[4:0]}.
  - 0xFF80–0xFFFE: HRAM, 127 bytes, index addr[6:0].
  - 0xFFFF: IE, all 8 bits read and written.
  - Everything else: reads UNMAPPED_VAL, writes are dropped.
- Writes:
  - Commit only on the rising edge of write_en: write_en=1 and the registered previous write_en=0.
  - The CPU holds write_en for two clocks (T2→T4); the second clock must not re-commit.
  - wdata and addr are sampled on the commit edge.
- Write/read same cycle on the same address: read-before-write. rdata returns old contents; new contents are visible from the next edge.
- read_en and write_en both high: write commits, and rdata follows the normal read rule.
- IF update per edge: IF_next = (cpu_write_IF ? wdata[4:0] : IF) | irq_req. A hardware set wins over a simultaneous CPU clear of the same bit.
- ROM preload:
  - rom_we writes ROM on the edge.
  - Same-edge ROM read returns old data.
  - rom_we is legal during reset.
- Reset mid-cycle:
  - Outputs return to reset values on the next edge.
  - An in-flight write committing on the same edge as reset is dropped.
  - The write-edge tracker is cleared, so write_en still high after reset deasserts counts as a new edge and commits.

Decomposition:
- Package bus_map_pkg holds:
  - region_t enum: REG_ROM, REG_WRAM, REG_ECHO, REG_IF, REG_HRAM, REG_IE, REG_NONE
  - address base/limit localparams
  - IRQ bit index constants
  - function decode_region(addr) -> region_t
- Sub-module byte_ram:
  - parameter AW
  - synchronous write, registered read
  - instanced for ROM (second write port muxed from preload), WRAM and HRAM.

Test Plan:
- ROM read: preload ROM[0x0100]=0x3C. Drive addr=0x0100 with the T1–T4 pattern → rdata=0x3C at the T3 edge. Write 0x55 to 0x0100 → ROM still reads 0x3C.
- WRAM/echo: write 0xA5 to 0xC123 → read 0xE123 = 0xA5. Write 0x5A to 0xE123 → read 0xC123 = 0x5A.
- Single commit: write_en held 2 clocks at 0xFF80 with wdata 0x01 then 0x02 on the second clock → HRAM[0]=0x01. Repeat with write_en dropping for one clock between → 0x02.
- IF race: IF=0x00. Same edge: CPU writes 0x00 to 0xFF0F and irq_req=5'b00100 → if_q=0x04, reading 0xFF0F returns 0xE4.
- Unmapped and IE: read 0xFF50 → 0xFF. Write 0x1F to 0xFFFF → ie_q=0x1F, read back 0x1F.
- Reset mid-write: assert reset on the commit edge of a write of 0x77 to 0xFFFF → ie_q=0x00, rdata=0xFF after the edge.

Source files
------------

// File: rtl/bus_map_pkg.sv
// bus_map_pkg: region decode, address map and interrupt bit indices for bus_responder
package bus_map_pkg;
  typedef enum logic [2:0] {REG_ROM, REG_WRAM, REG_ECHO, REG_IF, REG_HRAM, REG_IE, REG_NONE} region_t;
  localparam logic [15:0] ROM_LIMIT  = 16'h7FFF;
  localparam logic [15:0] WRAM_BASE  = 16'hC000;
  localparam logic [15:0] WRAM_LIMIT = 16'hDFFF;
  localparam logic [15:0] ECHO_BASE  = 16'hE000;
  localparam logic [15:0] ECHO_LIMIT = 16'hFDFF;
  localparam logic [15:0] IF_ADDR    = 16'hFF0F;
  localparam logic [15:0] HRAM_BASE  = 16'hFF80;
  localparam logic [15:0] HRAM_LIMIT = 16'hFFFE;
  localparam logic [15:0] IE_ADDR    = 16'hFFFF;
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;
  function automatic region_t decode_region(input logic [15:0] addr);
    return addr <= ROM_LIMIT                        ? REG_ROM  :
           (addr >= WRAM_BASE && addr <= WRAM_LIMIT) ? REG_WRAM :
           (addr >= ECHO_BASE && addr <= ECHO_LIMIT) ? REG_ECHO :
           addr == IF_ADDR                           ? REG_IF   :
           (addr >= HRAM_BASE && addr <= HRAM_LIMIT) ? REG_HRAM :
           addr == IE_ADDR                           ? REG_IE   : REG_NONE;
  endfunction
endpackage

// File: rtl/bus_if.sv
// Bus_if: CPU byte-wide memory bus
interface Bus_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        read_en;
  logic        write_en;
  modport Memory_side (input addr, wdata, read_en, write_en, output rdata);
  modport Cpu_side (output addr, wdata, read_en, write_en, input rdata);
endinterface

// File: rtl/byte_ram.sv
// byte_ram: byte array with synchronous write and registered read (old data on same-address collision)
module byte_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/bus_responder.sv
// bus_responder: decodes CPU bus accesses into ROM/WRAM/echo/HRAM/IF/IE with one-clock read latency
module bus_responder
  import bus_map_pkg::*;
#(
  parameter int         ROM_AW       = 15,
  parameter int         WRAM_AW      = 13,
  parameter logic [7:0] UNMAPPED_VAL = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  Bus_if.Memory_side        bus,
  input  logic              rom_we,
  input  logic [ROM_AW-1:0] rom_waddr,
  input  logic [7:0]        rom_wdata,
  input  logic [4:0]        irq_req,
  output logic [4:0]        if_q,
  output logic [7:0]        ie_q
);
  region_t    region, region_q;
  logic       we_q, commit;
  logic [7:0] reg_rd_q, rom_rd, wram_rd, hram_rd;
  logic [4:0] if_d;
  logic [7:0] ie_d;
  assign region = decode_region(bus.addr);
  // a write held across two clocks commits only on its first one; reset drops it
  assign commit = bus.write_en & ~we_q & ~reset;
  assign if_d = (commit && region == REG_IF ? bus.wdata[4:0] : if_q) | irq_req;
  assign ie_d = commit && region == REG_IE ? bus.wdata : ie_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      region_q <= REG_NONE;
      reg_rd_q <= UNMAPPED_VAL;
      if_q     <= '0;
      ie_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      region_q <= region;
      reg_rd_q <= region == REG_IF ? {3'b111, if_q} : region == REG_IE ? ie_q : UNMAPPED_VAL;
      if_q     <= if_d;
      ie_q     <= ie_d;
      we_q     <= bus.write_en;
    end
  end
  assign bus.rdata = region_q == REG_ROM                            ? rom_rd  :
                     (region_q == REG_WRAM || region_q == REG_ECHO) ? wram_rd :
                     region_q == REG_HRAM                           ? hram_rd : reg_rd_q;
  byte_ram #(.AW(ROM_AW)) u_rom (
    .clk(clk), .we_i(rom_we), .waddr_i(rom_waddr), .wdata_i(rom_wdata),
    .raddr_i(bus.addr[ROM_AW-1:0]), .rdata_o(rom_rd)
  );
  byte_ram #(.AW(WRAM_AW)) u_wram (
    .clk(clk), .we_i(commit && (region == REG_WRAM || region == REG_ECHO)),
    .waddr_i(bus.addr[WRAM_AW-1:0]), .wdata_i(bus.wdata),
    .raddr_i(bus.addr[WRAM_AW-1:0]), .rdata_o(wram_rd)
  );
  byte_ram #(.AW(7)) u_hram (
    .clk(clk), .we_i(commit && region == REG_HRAM),
    .waddr_i(bus.addr[6:0]), .wdata_i(bus.wdata),
    .raddr_i(bus.addr[6:0]), .rdata_o(hram_rd)
  );
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: scenario tasks with a read-data scoreboard queue for bus_responder
module tb_bus_responder;
  logic       clk = 0, reset = 1, rom_we = 0;
  logic [14:0] rom_waddr = '0;
  logic [7:0] rom_wdata = '0;
  logic [4:0] irq_req = '0;
  logic [4:0] if_q;
  logic [7:0] ie_q;
  int         total = 0, passed = 0;
  logic [7:0] exp_q [$];
  logic [7:0] e;
  Bus_if bus ();
  bus_responder dut (
    .clk(clk), .reset(reset), .bus(bus), .rom_we(rom_we), .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata), .irq_req(irq_req), .if_q(if_q), .ie_q(ie_q)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.addr = a; bus.wdata = d; bus.write_en = 1; tick(); tick();
    bus.write_en = 0; tick();
  endtask

  task automatic test_reset();
    bus.addr = 16'h0000; bus.wdata = 0; bus.read_en = 0; bus.write_en = 0;
    rom_we = 1; rom_waddr = 15'h0100; rom_wdata = 8'h3C;
    tick();
    rom_we = 0;
    tick();
    total++; if (bus.rdata !== 8'hFF) $display("FAIL reset_rdata got %h want ff", bus.rdata); else passed++;
    total++; if (if_q !== 5'h00) $display("FAIL reset_if got %h want 00", if_q); else passed++;
    total++; if (ie_q !== 8'h00) $display("FAIL reset_ie got %h want 00", ie_q); else passed++;
    reset = 0;
  endtask

  task automatic test_rom();
    bus.addr = 16'h0100; bus.read_en = 1; exp_q.push_back(8'h3C); tick(); tick();
    e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL rom_read got %h want %h", bus.rdata, e); else passed++;
    bus.read_en = 0;
    wr(16'h0100, 8'h55);
    exp_q.push_back(8'h3C); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL rom_readonly got %h want %h", bus.rdata, e); else passed++;
  endtask

  task automatic test_wram_echo();
    wr(16'hC123, 8'hA5);
    bus.addr = 16'hE123; exp_q.push_back(8'hA5); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL echo_read got %h want %h", bus.rdata, e); else passed++;
    wr(16'hE123, 8'h5A);
    bus.addr = 16'hC123; exp_q.push_back(8'h5A); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL echo_write got %h want %h", bus.rdata, e); else passed++;
    bus.wdata = 8'h11; bus.write_en = 1; exp_q.push_back(8'h5A); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL rbw_old got %h want %h", bus.rdata, e); else passed++;
    bus.write_en = 0; exp_q.push_back(8'h11); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL rbw_new got %h want %h", bus.rdata, e); else passed++;
  endtask

  task automatic test_single_commit();
    bus.addr = 16'hFF80; bus.wdata = 8'h01; bus.write_en = 1; tick();
    bus.wdata = 8'h02; tick();
    bus.write_en = 0; exp_q.push_back(8'h01); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL single_commit got %h want %h", bus.rdata, e); else passed++;
    bus.wdata = 8'h01; bus.write_en = 1; tick();
    bus.write_en = 0; tick();
    bus.wdata = 8'h02; bus.write_en = 1; tick();
    bus.write_en = 0; exp_q.push_back(8'h02); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL recommit got %h want %h", bus.rdata, e); else passed++;
    wr(16'hFFFE, 8'hC7);
    exp_q.push_back(8'hC7); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL hram_top got %h want %h", bus.rdata, e); else passed++;
  endtask

  task automatic test_if_race();
    total++; if (if_q !== 5'h00) $display("FAIL if_idle got %h want 00", if_q); else passed++;
    bus.addr = 16'hFF0F; bus.wdata = 8'h00; bus.write_en = 1; irq_req = 5'b00100;
    exp_q.push_back(8'hE0); tick(); e = exp_q.pop_front();
    irq_req = 0;
    total++; if (if_q !== 5'h04) $display("FAIL if_race got %h want 04", if_q); else passed++;
    total++; if (bus.rdata !== e) $display("FAIL if_rbw got %h want %h", bus.rdata, e); else passed++;
    exp_q.push_back(8'hE4); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL if_read got %h want %h", bus.rdata, e); else passed++;
    bus.write_en = 0; irq_req = 5'b00001; tick(); irq_req = 0;
    total++; if (if_q !== 5'h05) $display("FAIL if_set got %h want 05", if_q); else passed++;
    wr(16'hFF0F, 8'hE1);
    total++; if (if_q !== 5'h01) $display("FAIL if_clear got %h want 01", if_q); else passed++;
  endtask

  task automatic test_unmapped_ie();
    bus.addr = 16'hFF50; exp_q.push_back(8'hFF); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL unmapped_ff50 got %h want %h", bus.rdata, e); else passed++;
    wr(16'hA000, 8'h12);
    exp_q.push_back(8'hFF); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL unmapped_a000 got %h want %h", bus.rdata, e); else passed++;
    wr(16'hFFFF, 8'h1F);
    total++; if (ie_q !== 8'h1F) $display("FAIL ie_write got %h want 1f", ie_q); else passed++;
    exp_q.push_back(8'h1F); tick(); e = exp_q.pop_front();
    total++; if (bus.rdata !== e) $display("FAIL ie_read got %h want %h", bus.rdata, e); else passed++;
  endtask

  task automatic test_reset_mid_write();
    bus.addr = 16'hFFFF; bus.wdata = 8'h77; bus.write_en = 1; reset = 1; tick();
    total++; if (ie_q !== 8'h00) $display("FAIL rst_ie got %h want 00", ie_q); else passed++;
    total++; if (bus.rdata !== 8'hFF) $display("FAIL rst_rdata got %h want ff", bus.rdata); else passed++;
    reset = 0; bus.wdata = 8'h66; tick();
    total++; if (ie_q !== 8'h66) $display("FAIL rst_new_edge got %h want 66", ie_q); else passed++;
    bus.write_en = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  mdl [int];
    logic [12:0] idx [8];
    logic [7:0]  d;
    for (int i = 0; i < 8; i++) begin
      idx[i] = 13'($urandom_range(0, 8191)); d = 8'($urandom);
      mdl[int'(idx[i])] = d;
      wr((i % 2 ? 16'hE000 : 16'hC000) + {3'b000, idx[i]}, d);
    end
    for (int i = 0; i < 8; i++) begin
      bus.addr = (i % 2 ? 16'hC000 : 16'hE000) + {3'b000, idx[i]};
      exp_q.push_back(mdl[int'(idx[i])]); tick(); e = exp_q.pop_front();
      total++; if (bus.rdata !== e) $display("FAIL b2b_%0d got %h want %h", i, bus.rdata, e); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_rom();
    test_wram_echo();
    test_single_commit();
    test_if_race();
    test_unmapped_ie();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
